// File: rtl/data_mem_responder.sv
// Data-side load/store responder: word RAM with byte-lane stores, aligned load data,
// misaligned-store fault tracking and an MMIO page. Optional 64-bit cycle counter: DMEM_CYCLE_COUNTER_EN.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic        i_write,
   input  logic        i_load,
   input  logic [1:0]  i_size,
   output logic [31:0] o_rdata,
   output logic [31:0] o_out,
   output logic        o_fault
);
   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam logic [23:0] MMIO_PAGE = MMIO_BASE[31:8];
   localparam logic [1:0]  SZ_NONE = 2'b00;
   localparam logic [1:0]  SZ_BYTE = 2'b01;
   localparam logic [1:0]  SZ_HALF = 2'b10;
   localparam logic [1:0]  SZ_WORD = 2'b11;

   logic [31:0]   ram_q [DEPTH_WORDS];
   logic [AW-1:0] word_idx;
   logic [31:0]   ram_rd_word;
   logic [31:0]   ram_wr_word;
   logic [3:0]    lane_en;
   logic [4:0]    rd_shift;
   logic [5:0]    mmio_sel;
   logic          ram_hit;
   logic          mmio_hit;
   logic          misaligned;
   logic          store_ok;
   logic          fault_evt;
   logic          ram_we;
   logic          mmio_wr;
   logic [31:0]   mmio_rd;
   logic [63:0]   cycle_val;

   logic [31:0]   out_q, out_d;
   logic [31:0]   fault_cnt_q, fault_cnt_d;
   logic [31:0]   fault_addr_q, fault_addr_d;
   logic          fault_q, fault_d;

   assign word_idx    = i_addr[AW+1:2];
   assign ram_hit     = (i_addr[31:AW+2] == '0);
   assign mmio_hit    = (i_addr[31:8] == MMIO_PAGE) && !ram_hit;
   assign mmio_sel    = i_addr[7:2];
   assign rd_shift    = {i_addr[1:0], 3'b000};
   assign ram_rd_word = ram_q[word_idx];

   assign misaligned = ((i_size == SZ_HALF) && i_addr[0]) ||
                       ((i_size == SZ_WORD) && (i_addr[1:0] != 2'b00));
   // Faults only count for stores that land in a decoded region.
   assign fault_evt  = i_write && (ram_hit || mmio_hit) && misaligned;
   assign store_ok   = i_write && !i_rst && !misaligned && (i_size != SZ_NONE);
   assign ram_we     = store_ok && ram_hit;
   assign mmio_wr    = store_ok && mmio_hit && (i_size == SZ_WORD);

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_src;
      assign lane_en[gi] = (i_size == SZ_WORD) ||
                           ((i_size == SZ_HALF) && (i_addr[1] == 1'(gi >> 1))) ||
                           ((i_size == SZ_BYTE) && (i_addr[1:0] == 2'(gi)));
      assign lane_src = (i_size == SZ_BYTE) ? i_wdata[7:0] :
                        (i_size == SZ_HALF) ? i_wdata[8*(gi%2) +: 8] :
                                              i_wdata[8*gi +: 8];
      assign ram_wr_word[8*gi +: 8] = lane_en[gi] ? lane_src : ram_rd_word[8*gi +: 8];
   end

   always_ff @(posedge i_clk) begin
      if (ram_we) begin
         ram_q[word_idx] <= ram_wr_word;
      end
   end

`ifdef DMEM_CYCLE_COUNTER_EN
   logic [63:0] cycle_q;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cycle_q <= '0;
      end else begin
         cycle_q <= cycle_q + 64'd1;
      end
   end
   assign cycle_val = cycle_q;
`else
   assign cycle_val = '0;
`endif

   always_comb begin
      out_d        = out_q;
      fault_cnt_d  = fault_cnt_q;
      fault_addr_d = fault_addr_q;
      fault_d      = fault_evt;
      if (fault_evt) begin
         fault_cnt_d  = (fault_cnt_q == '1) ? fault_cnt_q : fault_cnt_q + 32'd1;
         fault_addr_d = i_addr;
      end
      if (mmio_wr && (mmio_sel == 6'h00)) begin
         out_d = i_wdata;
      end
      if (mmio_wr && (mmio_sel == 6'h01)) begin
         fault_cnt_d = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         out_q        <= '0;
         fault_cnt_q  <= '0;
         fault_addr_q <= '0;
         fault_q      <= 1'b0;
      end else begin
         out_q        <= out_d;
         fault_cnt_q  <= fault_cnt_d;
         fault_addr_q <= fault_addr_d;
         fault_q      <= fault_d;
      end
   end

   always_comb begin
      mmio_rd = '0;
      case (mmio_sel)
         6'h00:   mmio_rd = out_q >> rd_shift;
         6'h01:   mmio_rd = fault_cnt_q >> rd_shift;
         6'h02:   mmio_rd = fault_addr_q >> rd_shift;
         6'h04:   mmio_rd = cycle_val[31:0];
         6'h05:   mmio_rd = cycle_val[63:32];
         default: mmio_rd = '0;
      endcase
   end

   // Load data is combinational so it reflects pre-write contents during a store.
   always_comb begin
      o_rdata = '0;
      if (i_load) begin
         if (ram_hit) begin
            o_rdata = ram_rd_word >> rd_shift;
         end else if (mmio_hit) begin
            o_rdata = mmio_rd;
         end
      end
   end

   assign o_out   = out_q;
   assign o_fault = fault_q;

endmodule
